// File: rtl/adc_5g_snap_capture_if.sv
// Bundle of the demux-side sample bus, capture control and buffer readback
// signals for the snapshot capture block.
interface adc_5g_snap_capture_if #(
  parameter int SAMPLE_W   = 4,
  parameter int LANES      = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int OVR_W      = 16
);
  logic [LANES*SAMPLE_W-1:0]   data_i;
  logic [LANES*SAMPLE_W-1:0]   data_q;
  logic [3:0]                  sync_in;
  logic [1:0]                  ovr_in;
  logic                        data_valid;
  logic                        arm;
  logic                        trig_sel;
  logic [DEPTH_LOG2-1:0]       rd_addr;
  logic [2*LANES*SAMPLE_W-1:0] rd_data;
  logic                        busy;
  logic                        done;
  logic [1:0]                  trig_lane;
  logic [OVR_W-1:0]            ovr_count;

  // Host / demux side: drives samples and control, observes status and readback.
  modport master (
    output data_i, data_q, sync_in, ovr_in, data_valid, arm, trig_sel, rd_addr,
    input  rd_data, busy, done, trig_lane, ovr_count
  );

  // Capture block side.
  modport slave (
    input  data_i, data_q, sync_in, ovr_in, data_valid, arm, trig_sel, rd_addr,
    output rd_data, busy, done, trig_lane, ovr_count
  );
endinterface

// File: rtl/adc_5g_snap_capture.sv
// Snapshot capture of demuxed 5 GS/s ADC I/Q words. After an arm request the
// block waits for an immediate or sync-qualified trigger, then stores
// 2^DEPTH_LOG2 consecutive valid words into a block-RAM buffer that the host
// reads back through a registered addressed port. Over-range words seen during
// the capture are counted with saturation.
module adc_5g_snap_capture #(
  parameter int SAMPLE_W   = 4,
  parameter int LANES      = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int OVR_W      = 16
) (
  input logic                   ctrl_clk_in,
  input logic                   ctrl_reset_n,
  adc_5g_snap_capture_if.slave  bus
);
  localparam int WORD_W = 2*LANES*SAMPLE_W;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  trig_sel_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [OVR_W-1:0]      ovr_count_reg;
  logic [1:0]            trig_lane_reg;
  logic [WORD_W-1:0]     rd_data_reg;
  logic [1:0]            sync_lane;
  logic                  arm_accept;
  logic                  wr_en;
  logic                  trig_hit;

  logic [WORD_W-1:0]     mem [DEPTH];

  // Lowest set sync bit on the current word (0 when none are set).
  always_comb begin
    sync_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.sync_in[i]) sync_lane = 2'(i);
    end
  end

  // Next-state and control strobes; arm is only honoured from IDLE or DONE.
  always_comb begin
    state_next = state_reg;
    arm_accept = 1'b0;
    wr_en      = 1'b0;
    trig_hit   = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.arm) begin
          arm_accept = 1'b1;
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.data_valid && (!trig_sel_reg || (bus.sync_in != 4'd0))) begin
          trig_hit   = 1'b1;
          wr_en      = 1'b1;
          state_next = (wr_ptr_reg == LAST_ADDR) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.data_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_reg == LAST_ADDR) state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state_reg <= S_IDLE;
    else               state_reg <= state_next;
  end

  // Capture bookkeeping: trigger mode, write pointer, trigger lane, over-range count.
  always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      trig_sel_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      ovr_count_reg <= '0;
      trig_lane_reg <= 2'd0;
    end else if (arm_accept) begin
      trig_sel_reg  <= bus.trig_sel;
      wr_ptr_reg    <= '0;
      ovr_count_reg <= '0;
      trig_lane_reg <= 2'd0;
    end else if (wr_en) begin
      // After the last address the pointer rolls to 0, but the FSM is in DONE
      // so no further writes happen until the next arm resets it anyway.
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if ((bus.ovr_in != 2'd0) && (ovr_count_reg != {OVR_W{1'b1}}))
        ovr_count_reg <= ovr_count_reg + 1'b1;
      if (trig_hit)
        trig_lane_reg <= trig_sel_reg ? sync_lane : 2'd0;
    end
  end

  // Buffer write port; contents deliberately survive reset.
  always_ff @(posedge ctrl_clk_in) begin
    if (wr_en) mem[wr_ptr_reg] <= {bus.data_q, bus.data_i};
  end

  // Registered read port (read-first against a same-cycle write).
  always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) rd_data_reg <= '0;
    else               rd_data_reg <= mem[bus.rd_addr];
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.busy      = (state_reg == S_ARMED) || (state_reg == S_CAPTURE);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.trig_lane = trig_lane_reg;
  assign bus.ovr_count = ovr_count_reg;
endmodule

// File: doc/adc_5g_snap_capture.md
Name: adc_5g_snap_capture

Overview:
- Downstream consumer of the 5 GS/s ADC demux interface. Runs in the ADC-derived control clock domain (ctrl_clk_out of the demux).
- After an arm request, waits for a trigger: either immediate, or the first word with a demux sync bit set. It then records 2^DEPTH_LOG2 consecutive valid I/Q words into an internal buffer.
- Host logic reads the buffer back through a simple addressed port. A saturating counter reports ADC over-range events seen during the capture.

Parameters:
- SAMPLE_W, 4, bits per sample; matches demux user_datai*/user_dataq* width.
- LANES, 8, demuxed samples per clock per channel.
- DEPTH_LOG2, 9, log2 of buffer depth in words (default 512 words).
- OVR_W, 16, over-range counter width.

Ports:
- ctrl_clk_in  in  1  capture clock; the demux ctrl_clk_out.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- data_i  in  LANES*SAMPLE_W  packed user_datai0..7; lane 0 in the LSBs.
- data_q  in  LANES*SAMPLE_W  packed user_dataq0..7; lane 0 in the LSBs.
- sync_in  in  4  user_sync3..0.
- ovr_in  in  2  user_outofrange1..0.
- data_valid  in  1  user_data_valid.
- arm  in  1  single-cycle arm request.
- trig_sel  in  1  0 = trigger immediately, 1 = trigger on sync; sampled when arm is accepted.
- rd_addr  in  DEPTH_LOG2  readback address.
- rd_data  out  2*LANES*SAMPLE_W  {Q word, I word} at rd_addr.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- trig_lane  out  2  index of the lowest sync_in bit set on the trigger word; 0 for an immediate trigger.
- ovr_count  out  OVR_W  saturating count of captured words with any ovr_in bit set.

Behaviour:
- Reset (asynchronous, ctrl_reset_n=0) drives every output and register to 0: state=IDLE, busy=0, done=0, trig_lane=0, ovr_count=0, rd_data=0, write pointer=0. Buffer contents are not cleared.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE --arm--> ARMED. On that edge: latch trig_sel, clear ovr_count and trig_lane, set write pointer to 0.
  - ARMED --trigger--> CAPTURE.
  - CAPTURE --last word written--> DONE.
  - DONE --arm--> ARMED, with the same clearing actions; done falls on the cycle after arm.
- arm is ignored in ARMED and CAPTURE.
- Trigger condition: in ARMED with data_valid=1, and either latched trig_sel=0, or trig_sel=1 and sync_in!=0.
  - The trigger word itself is written to address 0 on the same edge.
  - trig_lane is latched from that word.
  - If that word is the only word needed (depth 1), the FSM goes straight to DONE.
- While armed, a word with data_valid=0 never triggers, even with sync_in set.
- Write rule: in CAPTURE, a word is written only when data_valid=1. The pointer increments per write.
  - Gaps with data_valid=0 stall the capture. They insert no entries and do not advance the pointer.
- The write of address 2^DEPTH_LOG2-1 moves the FSM to DONE on the same edge. The pointer does not wrap into further writes.
- ovr_count increments by 1 for each written word (including the trigger word) with ovr_in!=0. It saturates at 2^OVR_W-1 and never wraps.
- Buffer word layout: {data_q, data_i} as presented on the written cycle.
- Readback:
  - rd_data is registered, with 1-cycle latency from rd_addr.
  - Reads are permitted in any state.
  - Reading an address in the same cycle it is written returns the old contents (read-first).
- Reset mid-capture returns to IDLE immediately. A new arm is then required.
- Buffer: single write port, single read port, inferable as block RAM.

Test Plan:
- Reset, then arm with trig_sel=0 and data_valid=1 continuously, with an incrementing pattern on data_i/data_q -> busy=1 for 512 cycles, then done=1. Reading addresses 0..511 returns the pattern starting at the word present on the cycle after arm; rd_data lags rd_addr by 1 cycle.
- Arm with trig_sel=1; drive sync_in=4'b0100 on word 37 with data_valid=1 -> address 0 holds word 37, trig_lane=2. Words 0..36 are not stored.
- Arm with trig_sel=1; drive sync_in=4'b0001 while data_valid=0, then data_valid=1 with sync_in=0 -> no trigger; FSM stays in ARMED and busy stays 1.
- During capture, toggle data_valid in a 1-on/1-off pattern -> capture takes 1024 cycles; the stored sequence has no gaps and contains only the valid words.
- ovr_in=2'b01 on every word with OVR_W=4 -> ovr_count saturates at 15. A subsequent arm from DONE clears ovr_count to 0.
- Assert ctrl_reset_n=0 at write pointer 200 -> all outputs go to 0 immediately. A new arm restarts at address 0 and an arm pulse during CAPTURE is ignored.
